// File: rtl/modulo_unit_if.sv
// modulo_unit_if: start/operand request and result/status bundle for modulo_unit
interface modulo_unit_if;
  logic        modulo_start_i;
  logic [15:0] op_a_i;
  logic [15:0] op_b_i;
  logic [15:0] res_o;
  logic [15:0] quot_o;
  logic        modulo_ready_o;
  logic        busy_o;
  logic        div_zero_o;
  modport master (
    output modulo_start_i, op_a_i, op_b_i,
    input  res_o, quot_o, modulo_ready_o, busy_o, div_zero_o
  );
  modport slave (
    input  modulo_start_i, op_a_i, op_b_i,
    output res_o, quot_o, modulo_ready_o, busy_o, div_zero_o
  );
endinterface

// File: rtl/modulo_unit.sv
// modulo_unit: 16-bit unsigned restoring divider, fixed 16-step latency, remainder and quotient
module modulo_unit (
  input logic clk,
  input logic rst_i,
  modulo_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t      state;
  logic [3:0]  cnt;
  logic [16:0] r, r_sh, r_nx;
  logic [15:0] a, b, a_nx;
  logic        ge;
  // single restoring step: shift next dividend bit into R, subtract B when it fits
  always_comb begin
    r_sh = {r[15:0], a[15]};
    ge   = r_sh >= {1'b0, b};
    r_nx = ge ? r_sh - {1'b0, b} : r_sh;
    a_nx = {a[14:0], ge};
  end
  // control FSM with datapath registers and registered outputs
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state              <= IDLE;
      cnt                <= '0;
      r                  <= '0;
      a                  <= '0;
      b                  <= '0;
      bus.res_o          <= '0;
      bus.quot_o         <= '0;
      bus.modulo_ready_o <= 1'b0;
      bus.busy_o         <= 1'b0;
      bus.div_zero_o     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.modulo_ready_o <= 1'b0;
          if (bus.modulo_start_i) begin
            bus.busy_o <= 1'b1;
            if (bus.op_b_i != '0) begin
              state <= CALC;
              cnt   <= '0;
              r     <= '0;
              a     <= bus.op_a_i;
              b     <= bus.op_b_i;
            end else begin
              state              <= DONE;
              bus.res_o          <= bus.op_a_i;
              bus.quot_o         <= 16'hFFFF;
              bus.div_zero_o     <= 1'b1;
              bus.modulo_ready_o <= 1'b1;
            end
          end
        end
        CALC: begin
          r   <= r_nx;
          a   <= a_nx;
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            state              <= DONE;
            bus.res_o          <= r_nx[15:0];
            bus.quot_o         <= a_nx;
            bus.div_zero_o     <= 1'b0;
            bus.modulo_ready_o <= 1'b1;
          end
        end
        default: begin
          state              <= IDLE;
          bus.modulo_ready_o <= 1'b0;
          bus.busy_o         <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_modulo_unit.sv
// tb_modulo_unit: scoreboard bench with a cycle-accurate behavioural model of modulo_unit
module tb_modulo_unit;
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  modulo_unit_if bus();
  modulo_unit dut (.clk(clk), .rst_i(rst_i), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    logic [15:0] quot;
    logic        dz;
    int          due;
  } exp_t;
  exp_t q[$];

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  int busy_from = 1, busy_until = -1, next_ok = 0;
  logic en = 1'b0;
  logic [15:0] h_res = '0, h_quot = '0;
  logic h_dz = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
  endtask

  // monitor: pops the scoreboard on ready and checks held outputs every cycle
  always @(negedge clk) begin
    if (en) begin
      if (q.size() != 0 && q[0].due == cyc) begin
        exp_t e;
        e = q.pop_front();
        chk("ready_on_time", {31'd0, bus.modulo_ready_o}, 32'd1);
        h_res  = e.res;
        h_quot = e.quot;
        h_dz   = e.dz;
      end else begin
        chk("no_spurious_ready", {31'd0, bus.modulo_ready_o}, 32'd0);
      end
      chk("res", {16'd0, bus.res_o}, {16'd0, h_res});
      chk("quot", {16'd0, bus.quot_o}, {16'd0, h_quot});
      chk("div_zero", {31'd0, bus.div_zero_o}, {31'd0, h_dz});
      chk("busy", {31'd0, bus.busy_o}, {31'd0, (cyc >= busy_from && cyc <= busy_until)});
    end
  end

  // issue one operation at the earliest edge the unit can accept it; returns at a negedge
  task automatic op(input logic [15:0] a, input logic [15:0] b, input bit keep);
    int k;
    while (cyc + 1 < next_ok) @(negedge clk);
    bus.modulo_start_i = 1'b1;
    bus.op_a_i = a;
    bus.op_b_i = b;
    k = cyc + 1;
    @(posedge clk);
    q.push_back('{res: (b != 0) ? a % b : a, quot: (b != 0) ? a / b : 16'hFFFF,
                  dz: (b == 0), due: (b != 0) ? k + 16 : k});
    busy_from  = k;
    busy_until = (b != 0) ? k + 16 : k;
    next_ok    = busy_until + 2;
    @(negedge clk);
    if (!keep) bus.modulo_start_i = 1'b0;
    bus.op_a_i = 16'($urandom);
    bus.op_b_i = 16'($urandom);
  endtask

  task automatic pulse_start(input logic [15:0] a, input logic [15:0] b);
    bus.modulo_start_i = 1'b1;
    bus.op_a_i = a;
    bus.op_b_i = b;
    @(negedge clk);
    bus.modulo_start_i = 1'b0;
  endtask

  task automatic do_reset(input bit with_start);
    rst_i = 1'b1;
    bus.modulo_start_i = with_start;
    bus.op_a_i = 16'd77;
    bus.op_b_i = 16'd5;
    @(posedge clk);
    q.delete();
    h_res = '0;
    h_quot = '0;
    h_dz = 1'b0;
    busy_from = 1;
    busy_until = -1;
    next_ok = 0;
    en = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    bus.modulo_start_i = 1'b0;
  endtask

  initial begin
    logic [15:0] ra, rb;
    bus.modulo_start_i = 1'b0;
    bus.op_a_i = '0;
    bus.op_b_i = '0;
    @(negedge clk);
    do_reset(1'b1);
    op(16'd100, 16'd7, 1'b0);
    op(16'd7, 16'd100, 1'b0);
    op(16'hFFFF, 16'd1, 1'b0);
    op(16'h1234, 16'h1234, 1'b0);
    op(16'd55, 16'd0, 1'b0);
    op(16'd48, 16'd18, 1'b0);
    repeat (4) @(negedge clk);
    pulse_start(16'd9, 16'd4);
    op(16'd1000, 16'd3, 1'b0);
    repeat (7) @(negedge clk);
    do_reset(1'b1);
    op(16'd10, 16'd4, 1'b0);
    op(16'd0, 16'd0, 1'b0);
    op(16'hFFFF, 16'hFFFF, 1'b0);
    for (int i = 0; i < 30; i++) begin
      ra = 16'($urandom);
      rb = ($urandom_range(0, 5) == 0) ? 16'd0 :
           ($urandom_range(0, 1) == 0) ? 16'($urandom_range(1, 300)) : 16'($urandom);
      op(ra, rb, 1'b0);
    end
    for (int i = 0; i < 12; i++) begin
      ra = 16'($urandom);
      rb = (i % 4 == 1) ? 16'd0 : 16'($urandom_range(1, 65535));
      op(ra, rb, i != 11);
    end
    repeat (40) @(negedge clk);
    chk("scoreboard_drained", q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/modulo_unit.md
MODULO_UNIT -- requirements
Module: modulo_unit

Interface
REQ-001 SHALL have one clock, clk; reset rst_i is synchronous and active-high.
REQ-002 Port: clk  input  1  rising-edge system clock.
REQ-003 Port: rst_i  input  1  synchronous active-high reset.
REQ-004 Port: modulo_start_i  input  1  start request, sampled only in IDLE.
REQ-005 Port: op_a_i  input  16  dividend, unsigned, sampled with an accepted start.
REQ-006 Port: op_b_i  input  16  divisor, unsigned, sampled with an accepted start.
REQ-007 Port: res_o  output  16  remainder op_a mod op_b.
REQ-008 Port: quot_o  output  16  quotient op_a / op_b.
REQ-009 Port: modulo_ready_o  output  1  one-cycle pulse: res_o/quot_o newly valid.
REQ-010 Port: busy_o  output  1  high in CALC and DONE.
REQ-011 Port: div_zero_o  output  1  last completed operation had op_b == 0.

Function
REQ-012 SHALL implement a 3-state FSM: IDLE, CALC, DONE.
REQ-013 IDLE: start accepted at edge k when modulo_start_i=1; op_a_i/op_b_i latched at that edge; modulo_start_i=0 keeps IDLE.
REQ-014 Accepted start with op_b_i != 0: state becomes CALC at edge k, with iteration counter=0, partial remainder R (17 bit)=0 and shift register A=op_a_i.
REQ-015 CALC: one restoring-division step per edge: R={R[15:0],A[15]}, A=A<<1; if R>=B, R=R-B and A[0]=1, else A[0]=0.
REQ-016 CALC SHALL run exactly 16 steps, at edges k+1..k+16; state becomes DONE at edge k+16.
REQ-017 DONE lasts exactly one cycle; modulo_ready_o=1 only in DONE; state returns to IDLE at edge k+17.
REQ-018 Fixed latency: an accepted start at edge k gives modulo_ready_o high in the cycle after edge k+16 (17 cycles after the start edge).
REQ-019 res_o=R[15:0] and quot_o=A are updated when entering DONE and SHALL be held until the next completion or reset.
REQ-020 Accepted start with op_b_i == 0: state goes directly to DONE at edge k, with res_o=op_a, quot_o=16'hFFFF and div_zero_o=1; ready pulses in the cycle after edge k.
REQ-021 div_zero_o is updated at every completion (0 for a nonzero divisor) and held with the results.
REQ-022 modulo_start_i SHALL be ignored in CALC and DONE; latched operands SHALL NOT change mid-operation.
REQ-023 Results SHALL be exact for all unsigned 16-bit operands; op_a < op_b gives res=op_a and quot=0.
REQ-024 res_o and quot_o SHALL NOT change while busy_o=1, except at the edge entering DONE.
REQ-025 The block contains no combinational path from inputs to outputs.

Reset
REQ-026 rst_i=1 at an edge forces IDLE, counter=0, R=0, A=0, res_o=0, quot_o=0, modulo_ready_o=0, busy_o=0 and div_zero_o=0.
REQ-027 Reset SHALL override every state, including mid-CALC; the aborted operation produces no ready pulse.
REQ-028 A start that is high in the same cycle as rst_i SHALL be ignored.
REQ-029 The first start after reset deassertion is accepted normally.

Verification
REQ-030 a=100, b=7 -> after 17 cycles: ready pulse, res=2, quot=14, div_zero=0.
REQ-031 a=7, b=100 -> res=7, quot=0; a=0xFFFF, b=1 -> res=0, quot=0xFFFF; a=b=0x1234 -> res=0, quot=1.
REQ-032 a=55, b=0 -> ready in the cycle after the start edge, res=55, quot=0xFFFF, div_zero=1.
REQ-033 Start with a=48, b=18, then a second start with a=9, b=4 at step 5 -> second start ignored; result res=12, quot=2.
REQ-034 Start with a=1000, b=3, rst_i pulsed at step 8 -> no ready pulse; all outputs 0; a following start with a=10, b=4 gives res=2, quot=2.
REQ-035 Back-to-back: start asserted continuously -> next operation accepted in the first IDLE cycle after DONE; one ready pulse per operation; random-operand check against a reference mod/div model.
